axi_ni_receive_pinout_buffer: RTL and testbench

- Next-generation target-NI receive pinout stage.
- Replaces the purely combinational mask-and-drive of AW/AR/W with per-channel parametrised FIFOs that obey AXI VALID/READY back-pressure.
- Adds WLAST tracking with optional W-after-AW ordering.
- Sits between the NI receive FSM/decoder and the AXI target port of the cluster.

---
 rtl/axi_ni_receive_pinout_buffer_pkg.sv | 29 ++
 rtl/axi_ni_receive_pinout_buffer_if.sv | 53 +++++
 rtl/axi_ni_receive_pinout_buffer_fifo.sv | 51 +++++
 rtl/axi_ni_receive_pinout_buffer.sv | 123 ++++++++++++
 tb/tb_axi_ni_receive_pinout_buffer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/axi_ni_receive_pinout_buffer_pkg.sv
// rtl/axi_ni_receive_pinout_buffer_pkg.sv - shared AXI widths, command attribute struct and clog2 helper
package axi_ni_receive_pinout_buffer_pkg;

  localparam int AXIIDWD    = 4;
  localparam int AXILENWD   = 8;
  localparam int AXISIZEWD  = 3;
  localparam int AXIBURSTWD = 2;
  localparam int AXILOCKWD  = 2;
  localparam int AXICACHEWD = 4;
  localparam int AXIPROTWD  = 3;

  typedef struct packed {
    logic [AXIIDWD-1:0]    id;
    logic [AXILENWD-1:0]   len;
    logic [AXISIZEWD-1:0]  size;
    logic [AXIBURSTWD-1:0] burst;
    logic [AXILOCKWD-1:0]  lock;
    logic [AXICACHEWD-1:0] cache;
    logic [AXIPROTWD-1:0]  prot;
  } ax_attr_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_ni_receive_pinout_buffer_if.sv
// rtl/axi_ni_receive_pinout_buffer_if.sv - AXI AW/AR/W target-port bundle driven by the NI receive stage
interface axi_ni_receive_pinout_buffer_if
  import axi_ni_receive_pinout_buffer_pkg::*;
#(
  parameter int AXIAWADDRWD = 32,
  parameter int AXIARADDRWD = 32,
  parameter int AXIWDATAWD  = 32
);
  logic [AXIIDWD-1:0]      AWID;
  logic [AXIAWADDRWD-1:0]  AWADDR;
  logic [AXILENWD-1:0]     AWLEN;
  logic [AXISIZEWD-1:0]    AWSIZE;
  logic [AXIBURSTWD-1:0]   AWBURST;
  logic [AXILOCKWD-1:0]    AWLOCK;
  logic [AXICACHEWD-1:0]   AWCACHE;
  logic [AXIPROTWD-1:0]    AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [AXIIDWD-1:0]      ARID;
  logic [AXIARADDRWD-1:0]  ARADDR;
  logic [AXILENWD-1:0]     ARLEN;
  logic [AXISIZEWD-1:0]    ARSIZE;
  logic [AXIBURSTWD-1:0]   ARBURST;
  logic [AXILOCKWD-1:0]    ARLOCK;
  logic [AXICACHEWD-1:0]   ARCACHE;
  logic [AXIPROTWD-1:0]    ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [AXIIDWD-1:0]      WID;
  logic [AXIWDATAWD-1:0]   WDATA;
  logic [AXIWDATAWD/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
    input  AWREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    input  ARREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
    output AWREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    output ARREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY
  );
endinterface

// File: rtl/axi_ni_receive_pinout_buffer_fifo.sv
// rtl/axi_ni_receive_pinout_buffer_fifo.sv - ni_sync_fifo, power-of-two synchronous FIFO with head-entry output
module ni_sync_fifo
  import axi_ni_receive_pinout_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_en, rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/axi_ni_receive_pinout_buffer.sv
// rtl/axi_ni_receive_pinout_buffer.sv - NI receive pinout stage: AW/AR/W FIFOs, W credit gating, masked AXI outputs
module axi_ni_receive_pinout_buffer
  import axi_ni_receive_pinout_buffer_pkg::*;
#(
  parameter int AXIAWADDRWD  = 32,
  parameter int AXIARADDRWD  = 32,
  parameter int AXIWDATAWD   = 32,
  parameter int AW_DEPTH     = 2,
  parameter int AR_DEPTH     = 2,
  parameter int W_DEPTH      = 4,
  parameter int W_AFTER_AW   = 1,
  parameter int MAX_W_BURSTS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          aw_push,
  input  logic                          ar_push,
  input  logic                          wd_push,
  input  logic [AXIIDWD-1:0]            received_id,
  input  logic [((AXIAWADDRWD > AXIARADDRWD) ? AXIAWADDRWD : AXIARADDRWD)-1:0] received_address,
  input  logic [AXIWDATAWD-1:0]         received_data,
  input  logic [AXILENWD-1:0]           decoded_LEN,
  input  logic [AXISIZEWD-1:0]          decoded_SIZE,
  input  logic [AXIBURSTWD-1:0]         decoded_BURST,
  input  logic [AXILOCKWD-1:0]          decoded_LOCK,
  input  logic [AXICACHEWD-1:0]         decoded_CACHE,
  input  logic [AXIPROTWD-1:0]          decoded_PROT,
  input  logic [AXIWDATAWD/8-1:0]       decoded_WSTRB,
  input  logic                          decoded_WLAST,
  output logic                          aw_full,
  output logic                          ar_full,
  output logic                          wd_full,
  output logic                          overflow_err,
  axi_ni_receive_pinout_buffer_if.master axi
);
  localparam int AW_W = $bits(ax_attr_t) + AXIAWADDRWD;
  localparam int AR_W = $bits(ax_attr_t) + AXIARADDRWD;
  localparam int W_W  = AXIIDWD + AXIWDATAWD + AXIWDATAWD/8 + 1;
  localparam int CRW  = clog2(MAX_W_BURSTS + 1);

  ax_attr_t        attr, aw_attr, ar_attr;
  logic [AW_W-1:0] aw_head, aw_out;
  logic [AR_W-1:0] ar_head, ar_out;
  logic [W_W-1:0]  w_head, w_out;
  logic            aw_empty, ar_empty, w_empty, aw_fifo_full;
  logic            aw_hs, ar_hs, w_hs, wlast_hs, aw_acc;
  logic [CRW-1:0]  credit, owed;

  assign attr = '{id: received_id, len: decoded_LEN, size: decoded_SIZE, burst: decoded_BURST,
                  lock: decoded_LOCK, cache: decoded_CACHE, prot: decoded_PROT};

  ni_sync_fifo #(.WIDTH(AW_W), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk(clk), .rst_n(rst_n), .push(aw_acc), .wdata({attr, received_address[AXIAWADDRWD-1:0]}),
    .pop(aw_hs), .rdata(aw_head), .empty(aw_empty), .full(aw_fifo_full));

  ni_sync_fifo #(.WIDTH(AR_W), .DEPTH(AR_DEPTH)) u_ar_fifo (
    .clk(clk), .rst_n(rst_n), .push(ar_push), .wdata({attr, received_address[AXIARADDRWD-1:0]}),
    .pop(ar_hs), .rdata(ar_head), .empty(ar_empty), .full(ar_full));

  ni_sync_fifo #(.WIDTH(W_W), .DEPTH(W_DEPTH)) u_w_fifo (
    .clk(clk), .rst_n(rst_n), .push(wd_push),
    .wdata({received_id, received_data, decoded_WSTRB, decoded_WLAST}),
    .pop(w_hs), .rdata(w_head), .empty(w_empty), .full(wd_full));

  // owed counts accepted AWs (queued or issued) still awaiting WLAST; throttling on it
  // keeps credit bounded even when the AW FIFO still holds un-issued commands.
  assign aw_full  = aw_fifo_full || (owed == CRW'(MAX_W_BURSTS));
  assign aw_acc   = aw_push && !aw_full;

  assign axi.AWVALID = !aw_empty;
  assign axi.ARVALID = !ar_empty;
  assign axi.WVALID  = !w_empty && ((W_AFTER_AW == 0) || (credit != '0));

  assign aw_hs    = axi.AWVALID && axi.AWREADY;
  assign ar_hs    = axi.ARVALID && axi.ARREADY;
  assign w_hs     = axi.WVALID && axi.WREADY;
  assign wlast_hs = w_hs && axi.WLAST;

  assign aw_out = axi.AWVALID ? aw_head : '0;
  assign ar_out = axi.ARVALID ? ar_head : '0;
  assign w_out  = axi.WVALID  ? w_head  : '0;

  assign {aw_attr, axi.AWADDR} = aw_out;
  assign {ar_attr, axi.ARADDR} = ar_out;
  assign {axi.WID, axi.WDATA, axi.WSTRB, axi.WLAST} = w_out;

  assign axi.AWID    = aw_attr.id;
  assign axi.AWLEN   = aw_attr.len;
  assign axi.AWSIZE  = aw_attr.size;
  assign axi.AWBURST = aw_attr.burst;
  assign axi.AWLOCK  = aw_attr.lock;
  assign axi.AWCACHE = aw_attr.cache;
  assign axi.AWPROT  = aw_attr.prot;
  assign axi.ARID    = ar_attr.id;
  assign axi.ARLEN   = ar_attr.len;
  assign axi.ARSIZE  = ar_attr.size;
  assign axi.ARBURST = ar_attr.burst;
  assign axi.ARLOCK  = ar_attr.lock;
  assign axi.ARCACHE = ar_attr.cache;
  assign axi.ARPROT  = ar_attr.prot;

  // Decrements saturate at zero; only reachable when W is not ordered behind AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit       <= '0;
      owed         <= '0;
      overflow_err <= 1'b0;
    end else begin
      case ({aw_hs, wlast_hs})
        2'b10:   credit <= credit + 1'b1;
        2'b01:   credit <= (credit != '0) ? credit - 1'b1 : credit;
        default: credit <= credit;
      endcase
      case ({aw_acc, wlast_hs})
        2'b10:   owed <= owed + 1'b1;
        2'b01:   owed <= (owed != '0) ? owed - 1'b1 : owed;
        default: owed <= owed;
      endcase
      if ((aw_push && aw_full) || (ar_push && ar_full) || (wd_push && wd_full))
        overflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_ni_receive_pinout_buffer.sv
// tb/tb_axi_ni_receive_pinout_buffer.sv - directed scoreboard bench for the NI receive pinout buffer
module tb_axi_ni_receive_pinout_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        aw_push = 1'b0, ar_push = 1'b0, wd_push = 1'b0;
  logic [3:0]  received_id = '0;
  logic [31:0] received_address = '0;
  logic [31:0] received_data = '0;
  logic [7:0]  d_len = '0;
  logic [2:0]  d_size = 3'd2;
  logic [1:0]  d_burst = 2'd1;
  logic [1:0]  d_lock = 2'd0;
  logic [3:0]  d_cache = 4'd3;
  logic [2:0]  d_prot = 3'd2;
  logic [3:0]  d_wstrb = '0;
  logic        d_wlast = 1'b0;
  logic        aw_full, ar_full, wd_full, overflow_err;

  int tests = 0;
  int fails = 0;
  logic [63:0] aw_q[$], ar_q[$], w_q[$];

  axi_ni_receive_pinout_buffer_if axi ();

  axi_ni_receive_pinout_buffer dut (
    .clk(clk), .rst_n(rst_n), .aw_push(aw_push), .ar_push(ar_push), .wd_push(wd_push),
    .received_id(received_id), .received_address(received_address), .received_data(received_data),
    .decoded_LEN(d_len), .decoded_SIZE(d_size), .decoded_BURST(d_burst), .decoded_LOCK(d_lock),
    .decoded_CACHE(d_cache), .decoded_PROT(d_prot), .decoded_WSTRB(d_wstrb), .decoded_WLAST(d_wlast),
    .aw_full(aw_full), .ar_full(ar_full), .wd_full(wd_full), .overflow_err(overflow_err),
    .axi(axi));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input bit acc);
    aw_push = 1'b1; received_id = id; received_address = addr; d_len = len;
    if (acc) aw_q.push_back({id, addr, len, d_size, d_burst, d_lock, d_cache, d_prot});
    step();
    aw_push = 1'b0;
  endtask

  task automatic push_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input bit acc);
    ar_push = 1'b1; received_id = id; received_address = addr; d_len = len;
    if (acc) ar_q.push_back({id, addr, len, d_size, d_burst, d_lock, d_cache, d_prot});
    step();
    ar_push = 1'b0;
  endtask

  task automatic push_w(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb, input logic last, input bit acc);
    wd_push = 1'b1; received_id = id; received_data = data; d_wstrb = strb; d_wlast = last;
    if (acc) w_q.push_back({id, data, strb, last});
    step();
    wd_push = 1'b0;
  endtask

  task automatic do_reset();
    chk("drained_aw", aw_q.size(), 0);
    chk("drained_ar", ar_q.size(), 0);
    chk("drained_w", w_q.size(), 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Scoreboard: every handshake must match the oldest expected entry; idle channels must be zero.
  always @(negedge clk) begin
    logic [63:0] aw_obs, ar_obs, w_obs;
    aw_obs = {axi.AWID, axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST, axi.AWLOCK, axi.AWCACHE, axi.AWPROT};
    ar_obs = {axi.ARID, axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST, axi.ARLOCK, axi.ARCACHE, axi.ARPROT};
    w_obs  = {axi.WID, axi.WDATA, axi.WSTRB, axi.WLAST};
    if (!axi.AWVALID) chk("aw_mask", aw_obs, 0);
    if (!axi.ARVALID) chk("ar_mask", ar_obs, 0);
    if (!axi.WVALID)  chk("w_mask", w_obs, 0);
    if (rst_n) begin
      if (axi.AWVALID && axi.AWREADY) begin
        chk("aw_expected", aw_q.size() != 0, 1);
        if (aw_q.size() != 0) chk("aw_payload", aw_obs, aw_q.pop_front());
      end
      if (axi.ARVALID && axi.ARREADY) begin
        chk("ar_expected", ar_q.size() != 0, 1);
        if (ar_q.size() != 0) chk("ar_payload", ar_obs, ar_q.pop_front());
      end
      if (axi.WVALID && axi.WREADY) begin
        chk("w_expected", w_q.size() != 0, 1);
        if (w_q.size() != 0) chk("w_payload", w_obs, w_q.pop_front());
      end
    end
  end

  initial begin
    axi.AWREADY = 1'b0; axi.ARREADY = 1'b0; axi.WREADY = 1'b0;
    step();
    chk("rst_awvalid", axi.AWVALID, 0);
    chk("rst_arvalid", axi.ARVALID, 0);
    chk("rst_wvalid", axi.WVALID, 0);
    chk("rst_fulls", {aw_full, ar_full, wd_full}, 0);
    chk("rst_overflow", overflow_err, 0);
    rst_n = 1'b1;
    step();

    // AR single command, one-cycle VALID
    axi.ARREADY = 1'b1;
    push_ar(4'd3, 32'h1000, 8'd0, 1'b1);
    chk("ar_valid_t1", axi.ARVALID, 1);
    chk("ar_addr_t1", axi.ARADDR, 32'h1000);
    step();
    chk("ar_valid_t2", axi.ARVALID, 0);
    chk("ar_addr_t2", axi.ARADDR, 0);

    // AW back-pressure and overflow
    push_aw(4'd1, 32'hA000, 8'd1, 1'b1);
    push_aw(4'd2, 32'hB000, 8'd2, 1'b1);
    chk("aw_full_2", aw_full, 1);
    push_aw(4'd7, 32'hDEAD, 8'd7, 1'b0);
    chk("overflow_set", overflow_err, 1);
    axi.AWREADY = 1'b1;
    step();
    chk("aw_full_drop", aw_full, 0);
    chk("aw_second_valid", axi.AWVALID, 1);
    step();
    step();
    chk("aw_drained", axi.AWVALID, 0);
    chk("overflow_sticky", overflow_err, 1);
    do_reset();
    chk("overflow_cleared", overflow_err, 0);

    // W gated behind AW
    axi.AWREADY = 1'b0; axi.WREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_w(4'd5, 32'h100 + i, 4'hF, (i == 3), 1'b1);
      chk("w_gated", axi.WVALID, 0);
    end
    chk("wd_full_4", wd_full, 1);
    step();
    chk("w_still_gated", axi.WVALID, 0);
    axi.AWREADY = 1'b1;
    push_aw(4'd5, 32'h2000, 8'd3, 1'b1);
    chk("aw_before_w", {axi.AWVALID, axi.WVALID}, 2'b10);
    step();
    chk("w_after_aw", {axi.AWVALID, axi.WVALID}, 2'b01);
    for (int i = 0; i < 4; i++) step();
    chk("w_done", axi.WVALID, 0);
    chk("credit_zero", dut.credit, 0);

    // credit saturation
    for (int i = 0; i < 4; i++) push_aw(4'(8 + i), 32'h3000 + 32'(i * 16), 8'd0, 1'b1);
    chk("aw_full_credit", aw_full, 1);
    step();
    step();
    chk("aw_full_hold", aw_full, 1);
    chk("credit_max", dut.credit, 4);
    push_w(4'd8, 32'hCAFE, 4'h3, 1'b1, 1'b1);
    chk("wlast_valid", axi.WVALID, 1);
    chk("aw_full_pre", aw_full, 1);
    step();
    chk("aw_full_release", aw_full, 0);
    chk("credit_dec", dut.credit, 3);
    do_reset();

    // simultaneous AW and WLAST handshakes
    axi.AWREADY = 1'b1;
    push_aw(4'd4, 32'h4000, 8'd0, 1'b1);
    step();
    chk("credit_one", dut.credit, 1);
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
    push_aw(4'd6, 32'h5000, 8'd0, 1'b1);
    push_w(4'd4, 32'hBEEF, 4'hF, 1'b1, 1'b1);
    chk("both_valid", {axi.AWVALID, axi.WVALID}, 2'b11);
    axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
    step();
    chk("credit_same", dut.credit, 1);
    chk("both_done", {axi.AWVALID, axi.WVALID}, 2'b00);

    // asynchronous reset with entries queued
    axi.AWREADY = 1'b0; axi.ARREADY = 1'b0; axi.WREADY = 1'b0;
    push_ar(4'd1, 32'h6000, 8'd0, 1'b1);
    push_ar(4'd2, 32'h6100, 8'd0, 1'b1);
    push_ar(4'd3, 32'h6200, 8'd0, 1'b0);
    push_aw(4'd9, 32'h7000, 8'd1, 1'b1);
    push_w(4'd9, 32'h1234, 4'hF, 1'b0, 1'b1);
    chk("pre_rst_valids", {axi.ARVALID, axi.AWVALID, axi.WVALID}, 3'b111);
    chk("pre_rst_overflow", overflow_err, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_valids", {axi.ARVALID, axi.AWVALID, axi.WVALID}, 3'b000);
    chk("async_overflow", overflow_err, 0);
    aw_q.delete(); ar_q.delete(); w_q.delete();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valids", {axi.ARVALID, axi.AWVALID, axi.WVALID}, 3'b000);
    chk("post_rst_fulls", {aw_full, ar_full, wd_full}, 3'b000);
    chk("post_rst_credit", dut.credit, 0);
    axi.ARREADY = 1'b1;
    push_ar(4'd5, 32'h8000, 8'd2, 1'b1);
    chk("post_rst_ar", axi.ARVALID, 1);
    step();
    step();
    chk("final_aw_q", aw_q.size(), 0);
    chk("final_ar_q", ar_q.size(), 0);
    chk("final_w_q", w_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
